// File: rtl/alu_uart_host_if.sv
// Handshake bundle for the UART ALU host: command, operand words,
// tx/rx byte streams and result words. The host drives the master view.
interface alu_uart_host_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_add_i;
    logic [7:0]            cmd_count_i;
    logic                  word_valid_i;
    logic                  word_ready_o;
    logic [31:0]           word_i;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_ready_i;
    logic [DATA_WIDTH-1:0] rx_data_i;
    logic                  rx_valid_i;
    logic                  rx_ready_o;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [31:0]           res_data_o;
    logic                  res_last_o;
    logic                  busy_o;
    logic [1:0]            err_o;

    modport master (
        input  cmd_valid_i, cmd_add_i, cmd_count_i, word_valid_i, word_i,
               tx_ready_i, rx_data_i, rx_valid_i, res_ready_i,
        output cmd_ready_o, word_ready_o, tx_data_o, tx_valid_o, rx_ready_o,
               res_valid_o, res_data_o, res_last_o, busy_o, err_o
    );

    modport slave (
        output cmd_valid_i, cmd_add_i, cmd_count_i, word_valid_i, word_i,
               tx_ready_i, rx_data_i, rx_valid_i, res_ready_i,
        input  cmd_ready_o, word_ready_o, tx_data_o, tx_valid_o, rx_ready_o,
               res_valid_o, res_data_o, res_last_o, busy_o, err_o
    );
endinterface

// File: rtl/alu_uart_host.sv
// Host-side initiator for the UART ALU protocol: serializes an ECHO/ADD
// packet onto the tx byte stream and reassembles 32-bit result words
// from the rx byte stream.
module alu_uart_host #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    alu_uart_host_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, SEND_OP, SEND_RSVD, SEND_LEN_LSB, SEND_LEN_MSB,
        SEND_DATA, WAIT_ADD, DRAIN_ECHO
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic                  is_add;
    logic [7:0]            n_words;
    logic [7:0]            words_sent;
    logic [7:0]            res_cnt;
    logic                  word_held;
    logic [31:0]           word_shift;
    logic [1:0]            tx_byte;
    logic [31:0]           rx_shift;
    logic [1:0]            rx_byte;
    logic [31:0]           tcnt;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic                  res_valid_q;
    logic                  res_last_q;
    logic [31:0]           res_data_q;
    logic [1:0]            err_q;

    logic [15:0] len;
    logic        in_send, collect, rx_ready, word_ready;
    logic        cmd_fire, word_fire, tx_fire, rx_fire, res_fire;

    // LEN counts the 4-byte header plus 4 bytes per word.
    assign len     = 16'd4 + {6'd0, n_words, 2'd0};
    assign in_send = (state == SEND_OP) || (state == SEND_RSVD) || (state == SEND_LEN_LSB) ||
                     (state == SEND_LEN_MSB) || (state == SEND_DATA);
    // Echo bytes may return while the packet is still going out; ADD replies only after it.
    assign collect    = (in_send && !is_add) || (state == WAIT_ADD) || (state == DRAIN_ECHO);
    // NOTE: readies are decoded from registered state only, so no valid ever depends on a ready.
    assign rx_ready   = (state == IDLE) || (collect && !res_valid_q);
    assign word_ready = (state == SEND_DATA) && !word_held;

    assign cmd_fire  = bus.cmd_valid_i && (state == IDLE);
    assign word_fire = bus.word_valid_i && word_ready;
    assign tx_fire   = tx_valid_q && bus.tx_ready_i;
    assign rx_fire   = bus.rx_valid_i && rx_ready;
    assign res_fire  = res_valid_q && bus.res_ready_i;

    assign bus.cmd_ready_o  = (state == IDLE);
    assign bus.word_ready_o = word_ready;
    assign bus.rx_ready_o   = rx_ready;
    assign bus.tx_data_o    = tx_data_q;
    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_data_o   = res_data_q;
    assign bus.res_last_o   = res_last_q;
    assign bus.busy_o       = (state != IDLE);
    assign bus.err_o        = err_q;

    // Packet FSM, tx serializer, rx assembler and response timeout.
    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            is_add      <= 1'b0;
            n_words     <= 8'd0;
            words_sent  <= 8'd0;
            res_cnt     <= 8'd0;
            word_held   <= 1'b0;
            word_shift  <= 32'd0;
            tx_byte     <= 2'd0;
            rx_shift    <= 32'd0;
            rx_byte     <= 2'd0;
            tcnt        <= 32'd0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= 32'd0;
            err_q       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        err_q      <= 2'b00;
                        is_add     <= bus.cmd_add_i;
                        n_words    <= bus.cmd_count_i;
                        words_sent <= 8'd0;
                        res_cnt    <= 8'd0;
                        rx_byte    <= 2'd0;
                        word_held  <= 1'b0;
                        tcnt       <= 32'd0;
                        if (bus.cmd_count_i == 8'd0) begin
                            err_q <= 2'b10;
                        end else begin
                            state      <= SEND_OP;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= bus.cmd_add_i ? 8'hAD : 8'hEC;
                        end
                    end
                end
                SEND_OP: if (tx_fire) begin
                    tx_data_q <= 8'h00;
                    state     <= SEND_RSVD;
                end
                SEND_RSVD: if (tx_fire) begin
                    tx_data_q <= len[7:0];
                    state     <= SEND_LEN_LSB;
                end
                SEND_LEN_LSB: if (tx_fire) begin
                    tx_data_q <= len[15:8];
                    state     <= SEND_LEN_MSB;
                end
                SEND_LEN_MSB: if (tx_fire) begin
                    tx_valid_q <= 1'b0;
                    state      <= SEND_DATA;
                end
                SEND_DATA: begin
                    if (word_fire) begin
                        word_held  <= 1'b1;
                        word_shift <= bus.word_i;
                        tx_data_q  <= bus.word_i[7:0];
                        tx_valid_q <= 1'b1;
                        tx_byte    <= 2'd0;
                    end else if (tx_fire) begin
                        if (tx_byte == 2'd3) begin
                            word_held  <= 1'b0;
                            tx_valid_q <= 1'b0;
                            words_sent <= words_sent + 8'd1;
                            if (words_sent == n_words - 8'd1)
                                state <= is_add ? WAIT_ADD : DRAIN_ECHO;
                        end else begin
                            tx_byte    <= tx_byte + 2'd1;
                            tx_data_q  <= word_shift[15:8];
                            word_shift <= {8'h00, word_shift[31:8]};
                        end
                    end
                end
                WAIT_ADD, DRAIN_ECHO: begin
                    // Idle-rx watchdog; frozen while a pending result blocks rx.
                    if (rx_fire) begin
                        tcnt <= 32'd0;
                    end else if (rx_ready) begin
                        if (tcnt == TIMEOUT_LAST) begin
                            err_q       <= 2'b01;
                            state       <= IDLE;
                            rx_byte     <= 2'd0;
                            res_valid_q <= 1'b0;
                            res_last_q  <= 1'b0;
                            tcnt        <= 32'd0;
                        end else begin
                            tcnt <= tcnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Byte assembly runs alongside the tx path; rx is stalled, never dropped.
            if (collect && rx_fire) begin
                if (rx_byte == 2'd3) begin
                    res_data_q  <= {bus.rx_data_i[7:0], rx_shift[31:8]};
                    res_valid_q <= 1'b1;
                    res_last_q  <= is_add || (res_cnt == n_words - 8'd1);
                    res_cnt     <= res_cnt + 8'd1;
                    rx_byte     <= 2'd0;
                end else begin
                    rx_shift <= {bus.rx_data_i[7:0], rx_shift[31:8]};
                    rx_byte  <= rx_byte + 2'd1;
                end
            end

            if (res_fire) begin
                res_valid_q <= 1'b0;
                res_last_q  <= 1'b0;
                if (res_last_q && ((state == WAIT_ADD) || (state == DRAIN_ECHO)))
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_alu_uart_host.sv
// Directed bench for alu_uart_host: a vector table of whole commands plus
// hand-written sequences for backpressure, timeout, illegal count and reset.
module tb_alu_uart_host;
    localparam int TO = 50;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    alu_uart_host_if #(.DATA_WIDTH(8)) bus ();
    alu_uart_host #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic             add;
        logic [7:0]       n;
        logic [2:0][31:0] w;
        logic [31:0]      rsp;
        logic [7:0]       len_lsb;
        logic [7:0]       len_msb;
        logic [2:0][31:0] exp;
    } vec_t;

    vec_t        vecs[6];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  tx_log[$];
    logic [7:0]  rx_q[$];
    logic [32:0] res_log[$];
    int          tx_base  = 0;
    int          res_base = 0;
    bit          echo_en   = 1'b0;
    bit          tx_toggle = 1'b0;
    bit          rx_flush  = 1'b0;
    logic [31:0] words_in[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic add, input logic [7:0] n,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] rsp, input logic [7:0] lsb, input logic [7:0] msb,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        vecs[i].add = add;  vecs[i].n = n;
        vecs[i].w[0] = w0;  vecs[i].w[1] = w1;  vecs[i].w[2] = w2;
        vecs[i].rsp = rsp;  vecs[i].len_lsb = lsb;  vecs[i].len_msb = msb;
        vecs[i].exp[0] = e0;  vecs[i].exp[1] = e1;  vecs[i].exp[2] = e2;
    endtask

    // Transfer monitors: a valid&&ready seen at negedge completes on the next posedge.
    always @(negedge clk_i) begin
        if (rst_ni && bus.tx_valid_o && bus.tx_ready_i) begin
            tx_log.push_back(bus.tx_data_o);
            if (echo_en && (tx_log.size() - tx_base > 4)) rx_q.push_back(bus.tx_data_o);
        end
        if (rst_ni && bus.res_valid_o && bus.res_ready_i)
            res_log.push_back({bus.res_last_o, bus.res_data_o});
    end

    // rx byte source: presents queued bytes one at a time, holding until accepted.
    initial begin
        bit done;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        forever begin
            @(negedge clk_i);
            done = bus.rx_valid_i && bus.rx_ready_o;
            @(posedge clk_i);
            #1;
            if (done || rx_flush) bus.rx_valid_i = 1'b0;
            if (rx_flush) rx_q.delete();
            if (!bus.rx_valid_i && rx_q.size() > 0) begin
                bus.rx_data_i  = rx_q.pop_front();
                bus.rx_valid_i = 1'b1;
            end
        end
    end

    // tx sink readiness: always ready, or alternating when tx_toggle is set.
    initial begin
        bus.tx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            bus.tx_ready_i = tx_toggle ? !bus.tx_ready_i : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue_cmd(input logic add, input logic [7:0] n);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_add_i   = add;
        bus.cmd_count_i = n;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (bus.cmd_ready_o) break;
        end
        check("cmd_accept", bus.cmd_ready_o, 1);
        @(posedge clk_i);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic feed_words(input int n);
        for (int i = 0; i < n; i++) begin
            bus.word_valid_i = 1'b1;
            bus.word_i       = words_in[i % 3];
            for (int k = 0; k < 200; k++) begin
                @(negedge clk_i);
                if (bus.word_ready_o) break;
            end
            if (!bus.word_ready_o) check("word_accept", bus.word_ready_o, 1);
            @(posedge clk_i);
            #1;
            bus.word_valid_i = 1'b0;
        end
    endtask

    task automatic wait_res(input int k, input int budget);
        for (int j = 0; j < budget; j++) begin
            if (res_log.size() - res_base >= k) break;
            @(negedge clk_i);
        end
        check("res_count", res_log.size() - res_base, k);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int j = 0; j < budget; j++) begin
            @(negedge clk_i);
            if (!bus.busy_o) break;
        end
        check("busy_done", bus.busy_o, 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic mark();
        tx_base  = tx_log.size();
        res_base = res_log.size();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) rx_q.push_back(w[8*b +: 8]);
    endtask

    task automatic check_res(input string name, input int idx, input logic [31:0] data,
                             input logic last);
        logic [32:0] r;
        r = (res_base + idx < res_log.size()) ? res_log[res_base + idx] : 33'h0;
        check({name, "_data"}, r[31:0], data);
        check({name, "_last"}, {31'd0, r[32]}, {31'd0, last});
    endtask

    initial begin
        int          nres, errs, first, viol;
        logic [7:0]  eb;
        logic [31:0] wv;

        bus.cmd_valid_i  = 1'b0;
        bus.cmd_add_i    = 1'b0;
        bus.cmd_count_i  = 8'd0;
        bus.word_valid_i = 1'b0;
        bus.word_i       = 32'd0;
        bus.res_ready_i  = 1'b1;
        rst_ni = 1'b0;

        //           idx add  n    w0           w1           w2           rsp          lsb    msb    e0           e1           e2
        set_vec(0, 1'b1, 8'd2,   32'h5,        32'hA,        32'h0,        32'hF,        8'h0C, 8'h00, 32'hF,        32'h0,        32'h0);
        set_vec(1, 1'b0, 8'd1,   32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        8'h08, 8'h00, 32'hDEADBEEF, 32'h0,        32'h0);
        set_vec(2, 1'b1, 8'd3,   32'h1,        32'h2,        32'h3,        32'h6,        8'h10, 8'h00, 32'h6,        32'h0,        32'h0);
        set_vec(3, 1'b0, 8'd2,   32'h12345678, 32'hA5A55A5A, 32'h0,        32'h0,        8'h0C, 8'h00, 32'h12345678, 32'hA5A55A5A, 32'h0);
        set_vec(4, 1'b1, 8'd2,   32'hFFFFFFFF, 32'h2,        32'h0,        32'h1,        8'h0C, 8'h00, 32'h1,        32'h0,        32'h0);
        set_vec(5, 1'b1, 8'd255, 32'h1,        32'h1,        32'h1,        32'hFF,       8'h00, 8'h04, 32'hFF,       32'h0,        32'h0);

        // Reset values.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cmd_ready", bus.cmd_ready_o, 1);
        check("rst_rx_ready", bus.rx_ready_o, 1);
        check("rst_tx_valid", bus.tx_valid_o, 0);
        check("rst_word_ready", bus.word_ready_o, 0);
        check("rst_res_valid", bus.res_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Stray rx byte in IDLE is swallowed.
        rx_q.push_back(8'h99);
        repeat (5) @(posedge clk_i);
        #1;
        check("stray_drop_q", rx_q.size(), 0);
        check("stray_drop_valid", bus.rx_valid_i, 0);
        check("stray_no_res", bus.res_valid_o, 0);

        // Table of complete commands.
        foreach (vecs[v]) begin
            mark();
            echo_en = !vecs[v].add;
            for (int i = 0; i < 3; i++) words_in[i] = vecs[v].w[i];
            nres = vecs[v].add ? 1 : int'(vecs[v].n);
            issue_cmd(vecs[v].add, vecs[v].n);
            check($sformatf("v%0d_err_clear", v), bus.err_o, 0);
            if (vecs[v].add) push_word(vecs[v].rsp);
            feed_words(int'(vecs[v].n));
            wait_res(nres, 3000);
            check($sformatf("v%0d_busy_after_last", v), bus.busy_o, 0);
            wait_idle(50);
            check($sformatf("v%0d_tx_count", v), tx_log.size() - tx_base, 4 + 4 * int'(vecs[v].n));
            if (tx_log.size() - tx_base >= 4) begin
                check($sformatf("v%0d_opcode", v), tx_log[tx_base], vecs[v].add ? 8'hAD : 8'hEC);
                check($sformatf("v%0d_rsvd", v), tx_log[tx_base + 1], 8'h00);
                check($sformatf("v%0d_len_lsb", v), tx_log[tx_base + 2], vecs[v].len_lsb);
                check($sformatf("v%0d_len_msb", v), tx_log[tx_base + 3], vecs[v].len_msb);
            end
            errs = 0;
            first = -1;
            for (int b = 4; b < tx_log.size() - tx_base; b++) begin
                wv = vecs[v].w[((b - 4) / 4) % 3];
                eb = wv[8 * ((b - 4) % 4) +: 8];
                if (tx_log[tx_base + b] !== eb) begin
                    errs++;
                    if (first < 0) first = b;
                end
            end
            check($sformatf("v%0d_payload_errs_first_at_%0d", v, first), errs, 0);
            for (int r = 0; r < nres; r++)
                check_res($sformatf("v%0d_res%0d", v, r), r, vecs[v].exp[r], r == nres - 1);
            check($sformatf("v%0d_err_end", v), bus.err_o, 0);
        end
        echo_en = 1'b0;

        // ECHO N=3 with result backpressure and a toggling tx sink.
        mark();
        echo_en = 1'b1;
        tx_toggle = 1'b1;
        bus.res_ready_i = 1'b0;
        words_in[0] = 32'h01020304;
        words_in[1] = 32'hA0B0C0D0;
        words_in[2] = 32'hCAFEF00D;
        issue_cmd(1'b0, 8'd3);
        feed_words(3);
        viol = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (!(bus.res_valid_o && !bus.rx_ready_o)) viol++;
        end
        check("bp_rx_blocked_violations", viol, 0);
        @(posedge clk_i);
        #1;
        bus.res_ready_i = 1'b1;
        tx_toggle = 1'b0;
        wait_res(3, 300);
        wait_idle(50);
        check_res("bp_res0", 0, 32'h01020304, 1'b0);
        check_res("bp_res1", 1, 32'hA0B0C0D0, 1'b0);
        check_res("bp_res2", 2, 32'hCAFEF00D, 1'b1);
        check("bp_rx_drained", rx_q.size(), 0);
        check("bp_tx_count", tx_log.size() - tx_base, 16);
        echo_en = 1'b0;

        // ADD N=1 with no response: timeout.
        mark();
        words_in[0] = 32'h7;
        issue_cmd(1'b1, 8'd1);
        feed_words(1);
        for (int j = 0; j < 100; j++) begin
            if (tx_log.size() - tx_base >= 8) break;
            @(negedge clk_i);
        end
        repeat (30) @(negedge clk_i);
        check("to_not_early", bus.busy_o, 1);
        wait_idle(100);
        check("to_err", bus.err_o, 2'b01);
        check("to_cmd_ready", bus.cmd_ready_o, 1);
        check("to_no_res", res_log.size() - res_base, 0);

        // Illegal count: consumed, nothing sent, err=10 replaces the timeout status.
        mark();
        issue_cmd(1'b1, 8'd0);
        @(negedge clk_i);
        check("cnt0_err", bus.err_o, 2'b10);
        check("cnt0_busy", bus.busy_o, 0);
        check("cnt0_cmd_ready", bus.cmd_ready_o, 1);
        repeat (5) @(negedge clk_i);
        check("cnt0_no_tx", tx_log.size() - tx_base, 0);
        @(posedge clk_i);
        #1;

        // Following legal ADD clears the error and returns the all-ones sum.
        mark();
        words_in[0] = 32'hFFFFFFFF;
        issue_cmd(1'b1, 8'd1);
        check("after_cnt0_err_clear", bus.err_o, 0);
        push_word(32'hFFFFFFFF);
        feed_words(1);
        wait_res(1, 300);
        wait_idle(50);
        check_res("ones", 0, 32'hFFFFFFFF, 1'b1);

        // Reset asserted during SEND_DATA of ECHO N=2.
        mark();
        echo_en = 1'b1;
        words_in[0] = 32'h55AA55AA;
        words_in[1] = 32'h0F0F0F0F;
        issue_cmd(1'b0, 8'd2);
        feed_words(1);
        for (int j = 0; j < 100; j++) begin
            if (tx_log.size() - tx_base >= 6) break;
            @(negedge clk_i);
        end
        #2;
        rst_ni = 1'b0;
        rx_flush = 1'b1;
        echo_en = 1'b0;
        #1;
        check("mid_rst_cmd_ready", bus.cmd_ready_o, 1);
        check("mid_rst_rx_ready", bus.rx_ready_o, 1);
        check("mid_rst_tx_valid", bus.tx_valid_o, 0);
        check("mid_rst_tx_data", bus.tx_data_o, 0);
        check("mid_rst_word_ready", bus.word_ready_o, 0);
        check("mid_rst_res_valid", bus.res_valid_o, 0);
        check("mid_rst_res_last", bus.res_last_o, 0);
        check("mid_rst_res_data", bus.res_data_o, 0);
        check("mid_rst_busy", bus.busy_o, 0);
        check("mid_rst_err", bus.err_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        rx_flush = 1'b0;
        @(posedge clk_i);
        #1;

        // Fresh ECHO N=1 after the abandoned packet.
        mark();
        echo_en = 1'b1;
        words_in[0] = 32'h12345678;
        issue_cmd(1'b0, 8'd1);
        feed_words(1);
        wait_res(1, 300);
        wait_idle(50);
        check_res("post_rst", 0, 32'h12345678, 1'b1);
        check("post_rst_tx_count", tx_log.size() - tx_base, 8);
        check("post_rst_err", bus.err_o, 0);
        echo_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
